// File: rtl/logic_gate_n.sv
// rtl/logic_gate_n.sv - N-input registered reduction gate with glitch filter and saturating rise counter
// Majority for mode 6 is built only when LOGIC_GATE_N_MAJ_EN is defined; otherwise mode 6 gives 0.
module logic_gate_n #(
  parameter int N     = 3,
  parameter int FILT  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_vec,
  input  logic [2:0]       mode,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic             out_valid,
  output logic             z,
  output logic             z_filt,
  output logic [CNT_W-1:0] rise_cnt
);
  localparam int FC_W = (FILT < 2) ? 1 : $clog2(FILT + 1);
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILT);

  typedef enum logic [1:0] {LO_STABLE, PEND_HI, HI_STABLE, PEND_LO} filt_state_e;

  logic [N-1:0]     in_vec_q;
  logic [2:0]       mode_q;
  logic             v1_q;
  logic             z_q;
  logic             z_d;
  logic             out_valid_q;
  filt_state_e      state_q;
  logic [FC_W-1:0]  fc_q;
  logic [FC_W-1:0]  fc_next;
  logic             z_filt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hit_hi;
  logic             hit_lo;
  logic             rise;
  logic             all_one;
  logic             any_one;
  logic             parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      in_vec_q <= '0;
      mode_q   <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        in_vec_q <= in_vec;
        mode_q   <= mode;
      end
    end
  end

  assign all_one = &in_vec_q;
  assign any_one = |in_vec_q;
  assign parity  = ^in_vec_q;

`ifdef LOGIC_GATE_N_MAJ_EN
  localparam int PC_W = $clog2(N + 1);
  logic [PC_W-1:0] pop;
  logic            maj;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + PC_W'(in_vec_q[i]);
  end

  // Strict majority: an even N split exactly in half is not a majority.
  assign maj = (pop > PC_W'(N / 2));
`endif

  always_comb begin
    z_d = 1'b0;
    case (mode_q)
      3'd0: z_d = all_one;
      3'd1: z_d = any_one;
      3'd2: z_d = parity;
      3'd3: z_d = ~all_one;
      3'd4: z_d = ~any_one;
      3'd5: z_d = ~parity;
`ifdef LOGIC_GATE_N_MAJ_EN
      3'd6: z_d = maj;
`else
      3'd6: z_d = 1'b0;
`endif
      3'd7: z_d = all_one | ~any_one;
      default: z_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      z_q         <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) z_q <= z_d;
    end
  end

  assign hit_hi  = out_valid_q & z_q;
  assign hit_lo  = out_valid_q & ~z_q;
  assign fc_next = fc_q + FC_W'(1);
  assign rise    = hit_hi & (((state_q == LO_STABLE) && (FILT == 1)) ||
                             ((state_q == PEND_HI) && (fc_next == FC_MAX)));

  // Invalid cycles fall through every branch, so state and fc simply hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LO_STABLE;
      fc_q     <= '0;
      z_filt_q <= 1'b0;
    end else begin
      case (state_q)
        LO_STABLE: begin
          if (hit_hi) begin
            if (FILT == 1) begin
              state_q  <= HI_STABLE;
              z_filt_q <= 1'b1;
            end else begin
              state_q <= PEND_HI;
              fc_q    <= FC_W'(1);
            end
          end
        end
        PEND_HI: begin
          if (hit_hi) begin
            if (fc_next == FC_MAX) begin
              state_q  <= HI_STABLE;
              z_filt_q <= 1'b1;
              fc_q     <= '0;
            end else begin
              fc_q <= fc_next;
            end
          end else if (hit_lo) begin
            state_q <= LO_STABLE;
            fc_q    <= '0;
          end
        end
        HI_STABLE: begin
          if (hit_lo) begin
            if (FILT == 1) begin
              state_q  <= LO_STABLE;
              z_filt_q <= 1'b0;
            end else begin
              state_q <= PEND_LO;
              fc_q    <= FC_W'(1);
            end
          end
        end
        PEND_LO: begin
          if (hit_lo) begin
            if (fc_next == FC_MAX) begin
              state_q  <= LO_STABLE;
              z_filt_q <= 1'b0;
              fc_q     <= '0;
            end else begin
              fc_q <= fc_next;
            end
          end else if (hit_hi) begin
            state_q <= HI_STABLE;
            fc_q    <= '0;
          end
        end
        default: begin
          state_q <= LO_STABLE;
          fc_q    <= '0;
        end
      endcase
    end
  end

  // Clear takes priority over a rise landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_q <= '0;
    end else if (rise && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign z_filt    = z_filt_q;
  assign rise_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_gate_n.sv
// tb/tb_logic_gate_n.sv - directed vector bench for logic_gate_n (three parameterisations)
module tb_logic_gate_n;
`ifdef LOGIC_GATE_N_MAJ_EN
  localparam logic MAJ_ON = 1'b1;
`else
  localparam logic MAJ_ON = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] v3;
    logic [3:0] v4;
    logic [2:0] m;
    logic       e3;
    logic       e4;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, in_valid, clr_cnt;
  logic [2:0] mode;
  logic [2:0] in3;
  logic [3:0] in4;
  logic       ov_a, z_a, zf_a, ov_b, z_b, zf_b, ov_c, z_c, zf_c;
  logic [7:0] rc_a, rc_c;
  logic [1:0] rc_b;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  logic_gate_n #(.N(3), .FILT(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_vec(in3), .mode(mode), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .out_valid(ov_a), .z(z_a), .z_filt(zf_a), .rise_cnt(rc_a));
  logic_gate_n #(.N(3), .FILT(2), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_vec(in3), .mode(mode), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .out_valid(ov_b), .z(z_b), .z_filt(zf_b), .rise_cnt(rc_b));
  logic_gate_n #(.N(4), .FILT(1), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .in_vec(in4), .mode(mode), .in_valid(in_valid), .clr_cnt(clr_cnt),
    .out_valid(ov_c), .z(z_c), .z_filt(zf_c), .rise_cnt(rc_c));

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [2:0] d3, input logic [3:0] d4, input logic [2:0] m);
    in_valid = v; in3 = d3; in4 = d4; mode = m;
  endtask

  // One filtered rise and fall on u_b (FILT=2): results 1,1,0,0 then three idle cycles.
  task automatic rise_fall(input logic do_clr, input int exp_cnt, input int idx);
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, (i < 2) ? 3'b001 : 3'b000, 4'b0000, 3'd1);
      else drive(1'b0, 3'b000, 4'b0000, 3'd1);
      clr_cnt = do_clr && (i == 3);
      tick();
      if (i == 3) begin
        check("sat_zf_hi", idx, 32'(zf_b), 32'd1);
        check("sat_cnt", idx, 32'(rc_b), 32'(exp_cnt));
      end
    end
    clr_cnt = 1'b0;
    check("sat_zf_lo", idx, 32'(zf_b), 32'd0);
  endtask

  vec_t       tbl[15];
  logic [2:0] sw[8];
  logic       sw_e[8];
  logic [2:0] gl[6];

  initial begin
    tbl[0]  = '{3'b101, 4'b1011, 3'd1, 1'b1, 1'b1};
    tbl[1]  = '{3'b000, 4'b0000, 3'd1, 1'b0, 1'b0};
    tbl[2]  = '{3'b110, 4'b0111, 3'd2, 1'b0, 1'b1};
    tbl[3]  = '{3'b111, 4'b1111, 3'd2, 1'b1, 1'b0};
    tbl[4]  = '{3'b111, 4'b1110, 3'd3, 1'b0, 1'b1};
    tbl[5]  = '{3'b000, 4'b0100, 3'd4, 1'b1, 1'b0};
    tbl[6]  = '{3'b011, 4'b1000, 3'd5, 1'b1, 1'b0};
    tbl[7]  = '{3'b011, 4'b1010, 3'd0, 1'b0, 1'b0};
    tbl[8]  = '{3'b111, 4'b1111, 3'd0, 1'b1, 1'b1};
    tbl[9]  = '{3'b010, 4'b0110, 3'd7, 1'b0, 1'b0};
    tbl[10] = '{3'b000, 4'b0000, 3'd7, 1'b1, 1'b1};
    tbl[11] = '{3'b110, 4'b0011, 3'd6, MAJ_ON, 1'b0};
    tbl[12] = '{3'b001, 4'b0111, 3'd6, 1'b0, MAJ_ON};
    tbl[13] = '{3'b111, 4'b1111, 3'd6, MAJ_ON, MAJ_ON};
    tbl[14] = '{3'b111, 4'b1111, 3'd7, 1'b1, 1'b1};
    // (w,x,y) sweep mapped to {y,x,w}
    sw[0] = 3'b000; sw[1] = 3'b100; sw[2] = 3'b110; sw[3] = 3'b010;
    sw[4] = 3'b011; sw[5] = 3'b111; sw[6] = 3'b101; sw[7] = 3'b001;
    for (int i = 0; i < 8; i++) sw_e[i] = (i == 5);
    gl[0] = 3'b000; gl[1] = 3'b001; gl[2] = 3'b000; gl[3] = 3'b001; gl[4] = 3'b001; gl[5] = 3'b000;
    drive(1'b0, 3'b000, 4'b0000, 3'd0);

    // reset and idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_ov", i, {29'd0, ov_a, ov_b, ov_c}, 32'd0);
      check("idle_z", i, {29'd0, z_a, z_b, z_c}, 32'd0);
      check("idle_zf", i, {29'd0, zf_a, zf_b, zf_c}, 32'd0);
      check("idle_cnt", i, {22'd0, rc_a, rc_b}, 32'd0);
    end

    // mixed-mode vector table, back to back
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i < 15) drive(1'b1, tbl[i].v3, tbl[i].v4, tbl[i].m);
      else drive(1'b0, 3'b000, 4'b0000, 3'd0);
      tick();
      if (i >= 1) begin
        check("tbl_ov", i - 1, {30'd0, ov_a, ov_c}, 32'd3);
        check("tbl_z3", i - 1, 32'(z_a), 32'(tbl[i-1].e3));
        check("tbl_z4", i - 1, 32'(z_c), 32'(tbl[i-1].e4));
      end
    end
    tick();
    check("hold_ov", 0, {30'd0, ov_a, ov_c}, 32'd0);
    check("hold_z", 0, {30'd0, z_a, z_c}, 32'd3);

    // AND3 sweep on FILT=1 instance
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, sw[i], 4'b0000, 3'd0);
      else drive(1'b0, 3'b000, 4'b0000, 3'd0);
      tick();
      if (i >= 1 && i <= 8) check("and3_z", i - 1, 32'(z_a), 32'(sw_e[i-1]));
      if (i >= 2) check("and3_zf", i - 2, 32'(zf_a), 32'(sw_e[i-2]));
    end
    check("and3_cnt", 0, 32'(rc_a), 32'd1);

    // glitch rejection on FILT=2 instance
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive(1'b1, gl[i], 4'b0000, 3'd1);
      else drive(1'b0, 3'b000, 4'b0000, 3'd1);
      tick();
      check("glitch_zf", i, 32'(zf_b), (i >= 6) ? 32'd1 : 32'd0);
    end
    check("glitch_cnt", 0, 32'(rc_b), 32'd1);

    // invalid gaps between the two qualifying results
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive((i == 0) || (i == 4), 3'b001, 4'b0000, 3'd1);
      tick();
      check("gap_zf", i, 32'(zf_b), (i >= 6) ? 32'd1 : 32'd0);
    end
    check("gap_cnt", 0, 32'(rc_b), 32'd1);

    // saturation and clear priority on CNT_W=2
    do_reset();
    rise_fall(1'b0, 1, 0);
    rise_fall(1'b0, 2, 1);
    rise_fall(1'b0, 3, 2);
    rise_fall(1'b0, 3, 3);
    rise_fall(1'b0, 3, 4);
    rise_fall(1'b1, 0, 5);
    check("clr_cnt_end", 0, 32'(rc_b), 32'd0);

    // reset mid-pipeline discards in-flight results
    do_reset();
    drive(1'b1, 3'b111, 4'b1111, 3'd0);
    tick();
    tick();
    check("mid_ov_pre", 0, {30'd0, ov_a, ov_c}, 32'd3);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    check("mid_ov_r0", 0, {30'd0, ov_a, ov_c}, 32'd0);
    check("mid_z_r0", 0, {30'd0, z_a, z_c}, 32'd0);
    rst = 1'b0;
    tick();
    check("mid_ov_r1", 0, {30'd0, ov_a, ov_c}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_gate_n.md
Name: logic_gate_n

Overview:
- Parametrised, registered successor to the fixed 3-input AND gate exercise.
- N-input reduction gate with runtime-selectable logic function, 2-stage pipeline and valid flag.
- Adds a glitch filter on the result and a saturating rising-edge counter.
- Used as the generic gate block in lab benches, driven by stimulus modules that sweep input vectors.

Parameters:
- N, 3, number of gate inputs (>=2).
- FILT, 2, consecutive valid results of a new value needed before z_filt changes (>=1).
- CNT_W, 8, width of rise_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vec  in  N  gate inputs; bit 0 plays the role of the 3-input gate's first operand.
- mode  in  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 MAJ, 7 EQ (all bits equal).
- in_valid  in  1  qualifies in_vec/mode this cycle.
- clr_cnt  in  1  synchronous clear of rise_cnt.
- out_valid  out  1  z holds a new result this cycle.
- z  out  1  raw gate result.
- z_filt  out  1  filtered result.
- rise_cnt  out  CNT_W  count of z_filt 0->1 transitions, saturating.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, z=0, z_filt=0, rise_cnt=0, pipeline valids=0, filter state LO_STABLE, filter count=0. Reset mid-operation discards in-flight results.
- Stage 1: on edge with in_valid=1, register in_vec, mode and v1=1; otherwise v1=0 and data held.
- Stage 2: register z=f(mode, in_vec_r) and out_valid=v1. Latency: in_valid at cycle k gives out_valid=1 and z in cycle k+2. Back-to-back valids give one result per cycle. z holds its value when out_valid=0.
- Functions:
  - XOR = odd parity; XNOR = its inverse.
  - MAJ = 1 iff popcount > N/2 (strict; N even with exactly N/2 ones gives 0).
  - EQ = AND | NOR.
- Filter FSM states: LO_STABLE, PEND_HI, HI_STABLE, PEND_LO; counter fc counts up to FILT.
  - LO_STABLE: out_valid&z=1 -> if FILT=1 go HI_STABLE and set z_filt=1; else PEND_HI, fc=1.
  - PEND_HI:
    - out_valid&z=1 -> fc+1; when fc reaches FILT go HI_STABLE with z_filt=1.
    - out_valid&z=0 -> LO_STABLE, fc=0.
  - HI_STABLE / PEND_LO: symmetric, with z_filt going to 0.
  - out_valid=0 cycles hold state and fc (invalid cycles neither count nor break a run).
  - z_filt updates on the edge that samples the FILT-th qualifying result. With FILT=1, z_filt follows z one cycle later.
- rise_cnt:
  - +1 on the same edge z_filt goes 0->1; saturates at 2^CNT_W-1.
  - clr_cnt=1 forces 0, and wins over a simultaneous increment.
- Mode is sampled with data in stage 1; changing mode affects only subsequently valid inputs.

Optional Feature:
- Macro LOGIC_GATE_N_MAJ_EN.
- Defined: mode 6 computes majority as above (popcount logic instantiated).
- Undefined: popcount logic omitted; mode 6 yields z=0 whenever valid, and out_valid timing is unchanged.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then in_valid=0 for 10 cycles -> out_valid, z, z_filt, rise_cnt all 0 throughout.
- AND3 sweep: N=3, mode=0, FILT=1, one valid per cycle of (w,x,y) = 000, 001, 011, 010, 110, 111, 101, 100 -> z two cycles later = 0,0,0,0,0,1,0,0; z_filt pulses 1 for one cycle; rise_cnt=1.
- Glitch rejection: FILT=2, mode=1, results 0,1,0,1,1,0 -> z_filt rises only after the second consecutive 1 (one cycle after that result), stays high through the final single 0; rise_cnt=1.
- Invalid gaps: FILT=2, result 1, then 3 idle cycles, then result 1 -> z_filt rises after the second valid result; gaps neither reset nor advance fc.
- MAJ/EQ with N=4: in_vec=4'b0011 mode 6 -> z=0 (z=1 if macro defined and 4'b0111); 4'b0000 mode 7 -> z=1. Without the macro, mode 6 with 4'b1111 -> z=0.
- Saturation/clear: CNT_W=2, drive 5 filtered rises -> rise_cnt 1,2,3,3,3. Assert clr_cnt on the cycle of a 6th rise -> rise_cnt=0. Assert rst mid-pipeline -> out_valid=0 on the next 2 cycles.
